// File: rtl/line_fill_engine.sv
//------------------------------------------------------------------------------
// Module   : line_fill_engine
// Brief    : Read-side AXI burst engine. Accepts one cache-line fill request,
//            issues a single INCR burst of BEATS beats on AR, assembles the R
//            beats into one line and returns it on a valid/ready port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_fill_engine #(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    BEATS      = 16,
  parameter logic [ID_WIDTH-1:0]   REQ_ID     = '0
) (
  input  logic                         clk,
  input  logic                         reset,

  // Fill request from the cache bus arbiter
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        req_addr,

  // Assembled line back to the arbiter
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_WIDTH*BEATS-1:0]  resp_data,
  output logic                         resp_err,

  // AXI read address channel
  output logic [ID_WIDTH-1:0]          m_axi_arid,
  output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arlock,
  output logic [3:0]                   m_axi_arcache,
  output logic [2:0]                   m_axi_arprot,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,

  // AXI read data channel
  input  logic [ID_WIDTH-1:0]          m_axi_rid,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready
);

  //----------------------------------------------------------------------------
  // Derived constants
  //----------------------------------------------------------------------------
  // Beat counter width; a one-beat line still gets a 1-bit counter.
  localparam int c_BEAT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Byte offset bits inside one line (7 for 16 x 64-bit beats).
  localparam int c_OFFSET_BITS = $clog2(BEATS * DATA_WIDTH / 8);
  // AXI size encoding of one beat (bytes per beat as a power of two).
  localparam int c_ARSIZE      = $clog2(DATA_WIDTH / 8);

  localparam logic [c_BEAT_BITS-1:0] c_LAST_BEAT = c_BEAT_BITS'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0]  c_LINE_MASK = {ADDR_WIDTH{1'b1}} << c_OFFSET_BITS;

  //----------------------------------------------------------------------------
  // State encoding
  //----------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;  // waiting for a fill request
  localparam logic [1:0] S_ADDR = 2'd1;  // AR beat outstanding
  localparam logic [1:0] S_DATA = 2'd2;  // collecting R beats
  localparam logic [1:0] S_RESP = 2'd3;  // line waiting for the consumer

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;

  logic [ADDR_WIDTH-1:0]  r_araddr;
  logic [c_BEAT_BITS-1:0] r_beat_cnt;
  logic                   r_err;

  logic                   w_req_accept;
  logic                   w_beat_fire;
  logic                   w_last_slot;
  logic                   w_beat_err;
  logic                   w_data_done;

  //----------------------------------------------------------------------------
  // Handshake and beat qualification
  //----------------------------------------------------------------------------
  assign w_req_accept = (r_state == S_IDLE) && req_valid;
  // rready is decoded from S_DATA, so a beat is taken exactly when rvalid
  // arrives while in DATA; beats presented in any other state are ignored.
  assign w_beat_fire  = (r_state == S_DATA) && m_axi_rvalid;
  assign w_last_slot  = (r_beat_cnt == c_LAST_BEAT);

  // A beat is bad if the slave flags an error, answers with a foreign ID, or
  // places rlast anywhere other than the final slot (early or missing).
  assign w_beat_err   = (m_axi_rresp != 2'b00)
                      || (m_axi_rid != REQ_ID)
                      || (m_axi_rlast != w_last_slot);

  // The burst ends on the final slot or on the first rlast, whichever wins;
  // an early rlast leaves the remaining slots holding the previous line.
  assign w_data_done  = w_beat_fire && (w_last_slot || m_axi_rlast);

  //----------------------------------------------------------------------------
  // FSM
  //----------------------------------------------------------------------------
  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (req_valid)     w_next_state = S_ADDR;
      S_ADDR: if (m_axi_arready) w_next_state = S_DATA;
      S_DATA: if (w_data_done)   w_next_state = S_RESP;
      S_RESP: if (resp_ready)    w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state alone, keeping inputs off output paths.
  always_comb begin
    req_ready     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    resp_valid    = 1'b0;
    case (r_state)
      S_IDLE:  req_ready     = 1'b1;
      S_ADDR:  m_axi_arvalid = 1'b1;
      S_DATA:  m_axi_rready  = 1'b1;
      S_RESP:  resp_valid    = 1'b1;
      default: req_ready     = 1'b0;
    endcase
  end

  //----------------------------------------------------------------------------
  // Datapath
  //----------------------------------------------------------------------------
  // Line-aligned address latched on acceptance; held stable through ADDR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_araddr <= '0;
    end else if (w_req_accept) begin
      r_araddr <= req_addr & c_LINE_MASK;
    end
  end

  // Beat counter: cleared per fill, advanced per accepted beat, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat_cnt <= '0;
    end else if (w_req_accept) begin
      r_beat_cnt <= '0;
    end else if (w_beat_fire) begin
      r_beat_cnt <= r_beat_cnt + c_BEAT_BITS'(1);
    end
  end

  // Sticky error flag, cleared when a new fill is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_req_accept) begin
      r_err <= 1'b0;
    end else if (w_beat_fire) begin
      r_err <= r_err | w_beat_err;
    end
  end

  // One register per beat slot; a slot only changes when its beat arrives, so
  // the previous line persists until overwritten by the next fill.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_slot;

    // Capture the beat whose counter value selects this slot.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_slot <= '0;
      end else if (w_beat_fire && (r_beat_cnt == c_BEAT_BITS'(gi))) begin
        r_slot <= m_axi_rdata;
      end
    end

    assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_slot;
  end

  //----------------------------------------------------------------------------
  // Output assignments
  //----------------------------------------------------------------------------
  assign resp_err      = r_err;

  assign m_axi_arid    = REQ_ID;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'(c_ARSIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0000;
  assign m_axi_arprot  = 3'b000;

endmodule

`default_nettype wire

// File: tb/tb_line_fill_engine.sv
//------------------------------------------------------------------------------
// Module   : tb_line_fill_engine
// Brief    : Directed self-checking bench for line_fill_engine: basic fill,
//            backpressure, error responses, early rlast and reset mid-burst.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_fill_engine;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [63:0]   req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [1023:0] resp_data;
  logic          resp_err;
  logic [12:0]   m_axi_arid;
  logic [63:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [12:0]   m_axi_rid = '0;
  logic [63:0]   m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rlast = 1'b0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;

  int n_assert = 0;
  int n_fail   = 0;

  // Results of the most recent fill, written by run_fill.
  int            resp_cyc, first_rr, last_rr, first_ar, ar_hs, nacc;
  bit            addr_bad, resp_unstable, fill_done;
  logic [1023:0] got_line;
  logic          got_err;
  logic [63:0]   exp_slot [16];

  line_fill_engine dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arlock  (m_axi_arlock),
    .m_axi_arcache (m_axi_arcache),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_slots(input string tag);
    for (int s = 0; s < 16; s++)
      check($sformatf("%s_slot%0d", tag, s), got_line[s*64 +: 64], exp_slot[s]);
  endtask

  // One complete fill with a reactive AXI slave. Cycle 0 is the request
  // handshake cycle; all sampling and driving happens on the falling edge.
  task automatic run_fill(input logic [63:0] addr, input logic [63:0] base,
                          input int ar_wait, input bit gaps, input int resp_wait,
                          input int err_beat, input int id_beat, input int last_beat);
    int k, cyc, ar_seen, rv_seen;
    logic [63:0]   exp_addr;
    logic [1023:0] first_line;
    logic          first_err;
    exp_addr = addr & 64'hFFFF_FFFF_FFFF_FF80;
    k = 0; cyc = 0; ar_seen = 0; rv_seen = 0;
    resp_cyc = -1; first_rr = -1; last_rr = -1; first_ar = -1; ar_hs = 0;
    addr_bad = 0; resp_unstable = 0; fill_done = 0;
    first_line = '0; first_err = 1'b0;
    @(negedge clk);
    check("req_ready_before_fill", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    while (!fill_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
      // AR channel
      if (m_axi_arvalid) begin
        if (first_ar < 0) first_ar = cyc;
        if (m_axi_araddr !== exp_addr) addr_bad = 1;
        m_axi_arready = (ar_seen >= ar_wait);
        ar_seen++;
        if (m_axi_arready) ar_hs++;
      end else begin
        m_axi_arready = 1'b0;
      end
      // R channel
      if (m_axi_rready) begin
        if (first_rr < 0) first_rr = cyc;
        last_rr = cyc;
        if (k <= last_beat && !(gaps && $urandom_range(0, 2) == 0)) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = base + 64'(k);
          m_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
          m_axi_rid    = (k == id_beat) ? 13'd5 : 13'd0;
          m_axi_rlast  = (k == last_beat);
          exp_slot[k]  = base + 64'(k);
          k++;
        end else begin
          m_axi_rvalid = 1'b0;
        end
      end else begin
        // Stray beats outside DATA must not be consumed.
        m_axi_rvalid = gaps;
        m_axi_rdata  = 64'hDEAD_BEEF_0000_0000 | 64'(cyc);
        m_axi_rresp  = 2'b11;
        m_axi_rid    = 13'd7;
        m_axi_rlast  = 1'b1;
      end
      // Response port
      if (resp_valid) begin
        if (resp_cyc < 0) begin
          resp_cyc   = cyc;
          first_line = resp_data;
          first_err  = resp_err;
        end else if (resp_data !== first_line || resp_err !== first_err) begin
          resp_unstable = 1;
        end
        resp_ready = (rv_seen >= resp_wait);
        rv_seen++;
        if (resp_ready) begin
          fill_done = 1;
          got_line  = resp_data;
          got_err   = resp_err;
        end
      end else begin
        resp_ready = 1'b0;
      end
    end
    @(negedge clk);
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    resp_ready    = 1'b0;
    nacc          = k;
    check("fill_completed", fill_done, 1);
    check("req_ready_after_resp", req_ready, 1);
    check("resp_valid_dropped", resp_valid, 0);
    check("araddr_stable", addr_bad, 0);
    check("one_ar_handshake", ar_hs, 1);
    check("resp_stable", resp_unstable, 0);
    check("beats_accepted", nacc, last_beat + 1);
  endtask

  initial begin
    // Asynchronous reset
    #2 reset = 1'b0;
    #1;
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_resp_data_nonzero", |resp_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("arid_const", m_axi_arid, 0);
    check("arlen_const", m_axi_arlen, 15);
    check("arsize_const", m_axi_arsize, 3);
    check("arburst_const", m_axi_arburst, 1);
    check("arlock_cache_prot", {m_axi_arlock, m_axi_arcache, m_axi_arprot}, 0);

    // Basic fill
    run_fill(64'h8000_1234, 64'h1000, 0, 0, 0, -1, -1, 15);
    check("basic_ar_cycle", first_ar, 1);
    check("basic_rready_first", first_rr, 2);
    check("basic_rready_last", last_rr, 17);
    check("basic_resp_cycle", resp_cyc, 18);
    check("basic_err", got_err, 0);
    check("basic_slot0_hand", got_line[63:0], 64'h1000);
    check("basic_slot15_hand", got_line[1023:960], 64'h100F);
    check_slots("basic");

    // Backpressure on AR, R gaps, resp held off; stray beats outside DATA
    run_fill(64'h8000_1234, 64'h1000, 5, 1, 3, -1, -1, 15);
    check("bp_ar_cycles", first_rr - first_ar, 6);
    check("bp_err", got_err, 0);
    check("bp_slot7_hand", got_line[7*64 +: 64], 64'h1007);
    check_slots("bp");

    // SLVERR on beat 7
    run_fill(64'h4000_00C0, 64'h2000, 0, 0, 0, 7, -1, 15);
    check("slverr_err", got_err, 1);
    check("slverr_slot7_hand", got_line[7*64 +: 64], 64'h2007);
    check_slots("slverr");

    // Foreign ID on beat 3
    run_fill(64'h4000_0100, 64'h3000, 0, 0, 0, -1, 3, 15);
    check("rid_err", got_err, 1);
    check_slots("rid");

    // Early rlast on beat 9: slots 10..15 keep the previous line
    run_fill(64'h4000_017F, 64'h5000, 0, 0, 0, -1, -1, 9);
    check("early_resp_cycle", resp_cyc, 12);
    check("early_err", got_err, 1);
    check("early_slot9_hand", got_line[9*64 +: 64], 64'h5009);
    check("early_slot12_hand", got_line[12*64 +: 64], 64'h300C);
    check_slots("early");

    // Clean fill after errors: flag and counter must restart
    run_fill(64'h0000_0040, 64'h6000, 0, 0, 0, -1, -1, 15);
    check("clean_err", got_err, 0);
    check("clean_resp_cycle", resp_cyc, 18);
    check_slots("clean");

    // Reset asserted while beat 6 is on the bus
    @(negedge clk);
    check("mid_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = 64'h9000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_arvalid", m_axi_arvalid, 1);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    check("mid_rready", m_axi_rready, 1);
    for (int b = 0; b < 7; b++) begin
      if (b > 0) @(negedge clk);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 64'h7000 + 64'(b);
      m_axi_rresp  = 2'b00;
      m_axi_rid    = 13'd0;
      m_axi_rlast  = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("mid_rst_arvalid", m_axi_arvalid, 0);
    check("mid_rst_rready", m_axi_rready, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_resp_err", resp_err, 0);
    check("mid_rst_araddr", m_axi_araddr, 0);
    check("mid_rst_resp_data_nonzero", |resp_data, 0);
    m_axi_rvalid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_post_req_ready", req_ready, 1);
    run_fill(64'h9000_0040, 64'h8000, 0, 0, 0, -1, -1, 15);
    check("post_rst_err", got_err, 0);
    check("post_rst_resp_cycle", resp_cyc, 18);
    check_slots("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
